// File: rtl/sort_pkt_sanitizer.sv
// Avalon-ST packet sanitizer: drops orphan words, repairs missing EOPs, truncates long packets.
// Define SORT_SANITIZER_STATS_EN to build the saturating drop/trunc/repair counters.
`timescale 1ns/1ps

module sort_pkt_sanitizer #(
  parameter int DWIDTH      = 32,
  parameter int MAX_PKT_LEN = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o,
  output logic              src_valid_o,
  input  logic              src_ready_i,
  output logic [15:0]       drop_cnt_o,
  output logic [15:0]       trunc_cnt_o,
  output logic [15:0]       repair_cnt_o
);

  localparam int CW = $clog2(MAX_PKT_LEN + 1);

  typedef enum logic [1:0] {IDLE, IN_PKT, DISCARD} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              p_valid, p_sop, p_eop;
  logic [DWIDTH-1:0] p_data;

  logic accept, o_can_load, p_move;
  logic load_p, new_sop, new_eop, repair_ev;
  logic at_max;

  assign o_can_load = !src_valid_o || src_ready_i;
  // Uses snk_valid_i rather than accept so ready does not loop back on itself;
  // when P holds a non-EOP word, ready is only granted together with the move.
  assign p_move      = p_valid && o_can_load && (p_eop || snk_valid_i);
  assign snk_ready_o = !p_valid || p_move;
  assign accept      = snk_valid_i && snk_ready_o;
  assign at_max      = (cnt_q + CW'(1)) == CW'(MAX_PKT_LEN);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_p    = 1'b0;
    new_sop   = 1'b0;
    new_eop   = 1'b0;
    repair_ev = 1'b0;
    if (accept) begin
      if (snk_startofpacket_i) begin
        repair_ev = (state_q == IN_PKT) && p_valid;
        load_p    = 1'b1;
        new_sop   = 1'b1;
        new_eop   = snk_endofpacket_i;
        cnt_d     = CW'(1);
        state_d   = snk_endofpacket_i ? IDLE : IN_PKT;
      end else if (state_q == IN_PKT) begin
        load_p = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        if (snk_endofpacket_i) begin
          new_eop = 1'b1;
          state_d = IDLE;
        end else if (at_max) begin
          new_eop = 1'b1;
          state_d = DISCARD;
        end
      end else if (state_q == DISCARD && snk_endofpacket_i) begin
        state_d = IDLE;
      end
    end
  end

  // Pending stage P
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p_valid <= 1'b0;
      p_sop   <= 1'b0;
      p_eop   <= 1'b0;
      p_data  <= '0;
    end else if (load_p) begin
      p_valid <= 1'b1;
      p_sop   <= new_sop;
      p_eop   <= new_eop;
      p_data  <= snk_data_i;
    end else if (p_move) begin
      p_valid <= 1'b0;
    end
  end

  // Output stage O; a repaired packet gets its EOP as P moves out
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_valid_o         <= 1'b0;
      src_startofpacket_o <= 1'b0;
      src_endofpacket_o   <= 1'b0;
      src_data_o          <= '0;
    end else if (p_move) begin
      src_valid_o         <= 1'b1;
      src_startofpacket_o <= p_sop;
      src_endofpacket_o   <= p_eop | repair_ev;
      src_data_o          <= p_data;
    end else if (src_ready_i) begin
      src_valid_o <= 1'b0;
    end
  end

`ifdef SORT_SANITIZER_STATS_EN
  logic        drop_ev, trunc_ev;
  logic [15:0] drop_q, trunc_q, repair_q;

  assign drop_ev  = accept && !snk_startofpacket_i && (state_q != IN_PKT);
  assign trunc_ev = accept && !snk_startofpacket_i && !snk_endofpacket_i &&
                    (state_q == IN_PKT) && at_max;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_q   <= '0;
      trunc_q  <= '0;
      repair_q <= '0;
    end else begin
      if (drop_ev && drop_q != 16'hFFFF)     drop_q   <= drop_q + 16'd1;
      if (trunc_ev && trunc_q != 16'hFFFF)   trunc_q  <= trunc_q + 16'd1;
      if (repair_ev && repair_q != 16'hFFFF) repair_q <= repair_q + 16'd1;
    end
  end

  assign drop_cnt_o   = drop_q;
  assign trunc_cnt_o  = trunc_q;
  assign repair_cnt_o = repair_q;
`else
  assign drop_cnt_o   = '0;
  assign trunc_cnt_o  = '0;
  assign repair_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sort_pkt_sanitizer.sv
// Bench for sort_pkt_sanitizer with MAX_PKT_LEN=4; counter expectations follow
// whether SORT_SANITIZER_STATS_EN is defined for the build.
`timescale 1ns/1ps

module tb_sort_pkt_sanitizer;

  localparam int DW   = 32;
  localparam int MAXL = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [DW-1:0] snk_data_i = '0;
  logic          snk_startofpacket_i = 1'b0;
  logic          snk_endofpacket_i = 1'b0;
  logic          snk_valid_i = 1'b0;
  logic          snk_ready_o;
  logic [DW-1:0] src_data_o;
  logic          src_startofpacket_o;
  logic          src_endofpacket_o;
  logic          src_valid_o;
  logic          src_ready_i = 1'b1;
  logic [15:0]   drop_cnt_o, trunc_cnt_o, repair_cnt_o;

  always #5 clk_i = ~clk_i;

  sort_pkt_sanitizer #(.DWIDTH(DW), .MAX_PKT_LEN(MAXL)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .snk_data_i          (snk_data_i),
    .snk_startofpacket_i (snk_startofpacket_i),
    .snk_endofpacket_i   (snk_endofpacket_i),
    .snk_valid_i         (snk_valid_i),
    .snk_ready_o         (snk_ready_o),
    .src_data_o          (src_data_o),
    .src_startofpacket_o (src_startofpacket_o),
    .src_endofpacket_o   (src_endofpacket_o),
    .src_valid_o         (src_valid_o),
    .src_ready_i         (src_ready_i),
    .drop_cnt_o          (drop_cnt_o),
    .trunc_cnt_o         (trunc_cnt_o),
    .repair_cnt_o        (repair_cnt_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: word-stream rewrite, entries are {sop, eop, data}
  logic [33:0] exp_q[$];
  logic [33:0] last_w;
  bit          in_pkt;
  int          pkt_len;
  int          m_drop, m_trunc, m_repair;

  task automatic model_clear();
    exp_q.delete();
    in_pkt   = 0;
    pkt_len  = 0;
    m_drop   = 0;
    m_trunc  = 0;
    m_repair = 0;
  endtask

  task automatic model_accept(input logic [31:0] d, input bit sop, input bit eop);
    if (sop) begin
      if (in_pkt) begin
        last_w[32] = 1'b1;
        exp_q.push_back(last_w);
        m_repair++;
      end
      pkt_len = 1;
      if (eop) begin
        exp_q.push_back({2'b11, d});
        in_pkt = 0;
      end else begin
        last_w = {2'b10, d};
        in_pkt = 1;
      end
    end else if (in_pkt) begin
      exp_q.push_back(last_w);
      pkt_len++;
      if (eop || pkt_len == MAXL) begin
        exp_q.push_back({2'b01, d});
        if (!eop) m_trunc++;
        in_pkt = 0;
      end else begin
        last_w = {2'b00, d};
      end
    end else begin
      m_drop++;
    end
  endtask

  function automatic logic [63:0] stat(input int v);
`ifdef SORT_SANITIZER_STATS_EN
    return 64'(v);
`else
    return 64'(v * 0);
`endif
  endfunction

  // Monitor: compares every emitted word and feeds every accepted word to the model
  always @(negedge clk_i) begin
    logic [33:0] w;
    if (!rst_i) begin
      if (src_valid_o && src_ready_i) begin
        check_eq("exp_avail", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check_eq("out_word", {30'b0, src_startofpacket_o, src_endofpacket_o, src_data_o}, {30'b0, w});
        end
      end
      if (snk_valid_i && snk_ready_o)
        model_accept(snk_data_i, snk_startofpacket_i, snk_endofpacket_i);
    end
  end

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    snk_valid_i = 1'b0; snk_startofpacket_i = 1'b0; snk_endofpacket_i = 1'b0;
    src_ready_i = 1'b1;
    model_clear();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 of the accepting edge
  task automatic send_word(input logic [31:0] d, input bit sop, input bit eop);
    int n;
    n = 0;
    snk_data_i = d; snk_startofpacket_i = sop; snk_endofpacket_i = eop; snk_valid_i = 1'b1;
    @(negedge clk_i);
    while (!snk_ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 100) check_eq("accept_timeout", 64'(n), 64'd0);
    @(posedge clk_i); #1;
    snk_valid_i = 1'b0; snk_startofpacket_i = 1'b0; snk_endofpacket_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    src_ready_i = 1'b1;
    snk_valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    check_eq(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_clear();
    #1;
    check_eq("rst_src_valid", 64'(src_valid_o), 64'd0);
    check_eq("rst_src_flags", {62'b0, src_startofpacket_o, src_endofpacket_o}, 64'd0);
    check_eq("rst_src_data", 64'(src_data_o), 64'd0);
    check_eq("rst_counters", {16'b0, drop_cnt_o, trunc_cnt_o, repair_cnt_o}, 64'd0);
    check_eq("rst_snk_ready", 64'(snk_ready_o), 64'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Clean packet and EOP latency
    do_reset();
    send_word(5, 1, 0);
    send_word(3, 0, 0);
    send_word(9, 0, 1);
    @(negedge clk_i);
    check_eq("eop_lat_early", 64'(src_valid_o && src_endofpacket_o), 64'd0);
    @(negedge clk_i);
    check_eq("eop_lat_2", {31'b0, src_valid_o, src_endofpacket_o, src_data_o}, {31'b0, 1'b1, 1'b1, 32'd9});
    drain("drain_clean");
    check_eq("clean_drop", 64'(drop_cnt_o), 64'd0);
    check_eq("clean_trunc", 64'(trunc_cnt_o), 64'd0);
    check_eq("clean_repair", 64'(repair_cnt_o), 64'd0);

    // Orphan words dropped
    do_reset();
    send_word(7, 0, 0);
    send_word(8, 0, 0);
    send_word(1, 1, 1);
    drain("drain_orphan");
    check_eq("orphan_drop", 64'(drop_cnt_o), stat(2));

    // Truncation at MAX_PKT_LEN
    do_reset();
    send_word(32'hA, 1, 0);
    send_word(32'hB, 0, 0);
    send_word(32'hC, 0, 0);
    send_word(32'hD, 0, 0);
    send_word(32'hE, 0, 0);
    send_word(32'hF, 0, 1);
    drain("drain_trunc");
    check_eq("trunc_trunc", 64'(trunc_cnt_o), stat(1));
    check_eq("trunc_drop", 64'(drop_cnt_o), stat(2));

    // Missing EOP repaired on next SOP
    do_reset();
    send_word(1, 1, 0);
    send_word(2, 0, 0);
    send_word(3, 1, 0);
    send_word(4, 0, 1);
    drain("drain_repair");
    check_eq("repair_cnt", 64'(repair_cnt_o), stat(1));

    // Back-pressure for 10 cycles
    do_reset();
    src_ready_i = 1'b0;
    send_word(1, 1, 0);
    send_word(2, 0, 0);
    snk_data_i = 3; snk_valid_i = 1'b1;
    repeat (10) @(negedge clk_i);
    check_eq("stall_snk_ready", 64'(snk_ready_o), 64'd0);
    check_eq("stall_hold_o", {31'b0, src_valid_o, src_startofpacket_o, src_data_o}, {31'b0, 1'b1, 1'b1, 32'd1});
    @(posedge clk_i); #1;
    src_ready_i = 1'b1;
    send_word(3, 0, 0);
    send_word(4, 0, 1);
    drain("drain_stall");

    // Reset in the middle of a packet
    do_reset();
    send_word(1, 1, 0);
    send_word(2, 0, 0);
    send_word(3, 0, 0);
    @(negedge clk_i); #2;
    rst_i = 1'b1;
    #1;
    check_eq("midrst_valid", 64'(src_valid_o), 64'd0);
    model_clear();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    send_word(9, 1, 0);
    send_word(8, 0, 1);
    n = 0;
    while (!src_valid_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 20) check_eq("midrst_timeout", 64'(n), 64'd0);
    check_eq("midrst_sop", {31'b0, src_startofpacket_o, src_data_o}, {31'b0, 1'b1, 32'd9});
    drain("drain_midrst");

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      @(posedge clk_i); #1;
      snk_valid_i         = ($urandom_range(0, 3) != 0);
      snk_startofpacket_i = ($urandom_range(0, 3) == 0);
      snk_endofpacket_i   = ($urandom_range(0, 3) == 0);
      snk_data_i          = $urandom;
      src_ready_i         = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk_i); #1;
    drain("drain_rand");
    check_eq("rand_drop", 64'(drop_cnt_o), stat(m_drop));
    check_eq("rand_trunc", 64'(trunc_cnt_o), stat(m_trunc));
    check_eq("rand_repair", 64'(repair_cnt_o), stat(m_repair));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
